// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_if
// Brief    : Master-side request/grant bundle of the shared serial system bus.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 3,
  parameter int unsigned SEL_W       = 2
);
  logic [NUM_MASTERS-1:0]       mreq;
  logic [NUM_MASTERS-1:0]       mdone;
  logic [NUM_MASTERS*SEL_W-1:0] msel;
  logic [NUM_MASTERS-1:0]       mgrant;
  logic [1:0]                   owner;
  logic                         bus_busy;
  logic [NUM_SLAVES-1:0]        slave_en;
  logic                         sel_err;
  logic                         timeout;

  modport master (
    output mreq, mdone, msel,
    input  mgrant, owner, bus_busy, slave_en, sel_err, timeout
  );

  modport slave (
    input  mreq, mdone, msel,
    output mgrant, owner, bus_busy, slave_en, sel_err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin bus arbiter with one-hot slave routing.
//            Optional forced release after TIMEOUT_CYCLES: define ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 3,
  parameter int unsigned SEL_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire logic    clk,
  input  wire logic    reset,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  mgrant_q, mgrant_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              last_owner_q, last_owner_d;
  logic                    bus_busy_q, bus_busy_d;
  logic [NUM_SLAVES-1:0]   slave_en_q, slave_en_d;
  logic                    sel_err_q, sel_err_d;
  logic                    timeout_q, timeout_d;

  logic                    win_found;
  logic [1:0]              win_idx;
  logic [SEL_W-1:0]        win_sel;
  logic                    own_req;
  logic                    own_done;
  logic                    sel_bad;
  logic                    timeout_hit;
  logic                    release_req;

  // Two passes give the rotation: masters above last_owner first, then wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (!win_found && (i > int'(last_owner_q)) && bus.mreq[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (!win_found && (i <= int'(last_owner_q)) && bus.mreq[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    win_sel = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (win_idx == 2'(i)) begin
        win_sel = bus.msel[i*SEL_W +: SEL_W];
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_done = 1'b0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (owner_q == 2'(i)) begin
        own_req  = bus.mreq[i];
        own_done = bus.mdone[i];
      end
    end
  end

  // An in-range grant always has one slave enabled, so an empty enable marks a bad id.
  assign sel_bad     = (slave_en_q == '0);
  assign release_req = own_done | ~own_req | sel_bad | timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] count_q, count_d;

  assign timeout_hit = (state_q == ST_BUSY) && (count_q == c_cnt_w'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = '0;
    if ((state_q == ST_BUSY) && !release_req) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mgrant_d     = mgrant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    bus_busy_d   = bus_busy_q;
    slave_en_d   = slave_en_q;
    sel_err_d    = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_BUSY;
          owner_d    = win_idx;
          bus_busy_d = 1'b1;
          for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            mgrant_d[i] = (win_idx == 2'(i));
          end
          for (int j = 0; j < int'(NUM_SLAVES); j++) begin
            slave_en_d[j] = (win_sel == SEL_W'(j));
          end
          sel_err_d = (int'(win_sel) >= int'(NUM_SLAVES));
        end
      end
      ST_BUSY: begin
        if (release_req) begin
          state_d      = ST_RELEASE;
          mgrant_d     = '0;
          slave_en_d   = '0;
          bus_busy_d   = 1'b0;
          last_owner_d = owner_q;
          // Only flag a timeout when nothing else would have released the bus.
          timeout_d    = timeout_hit & ~(own_done | ~own_req | sel_bad);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mgrant_q     <= '0;
      owner_q      <= '0;
      last_owner_q <= 2'(NUM_MASTERS - 1);
      bus_busy_q   <= 1'b0;
      slave_en_q   <= '0;
      sel_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mgrant_q     <= mgrant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bus_busy_q   <= bus_busy_d;
      slave_en_q   <= slave_en_d;
      sel_err_q    <= sel_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.mgrant   = mgrant_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = bus_busy_q;
  assign bus.slave_en = slave_en_q;
  assign bus.sel_err  = sel_err_q;
  assign bus.timeout  = timeout_q;

endmodule
`default_nettype wire
